mc_controller: RTL and testbench

Multicycle control unit for the RV32I core. It is the sequential successor of the single-cycle main decoder: a Moore FSM steps each instruction through fetch, decode, execute, memory and writeback over several cycles on a shared ALU and a unified memory. Over the single-cycle decoder it adds bne/jalr, optional lui/auipc, an optional memory-ready handshake and an illegal-opcode flag. It sits between the instruction register, the ALU decoder (driven by `ALUOp`), and the datapath muxes and enables.

---
 rtl/mc_controller_if.sv | 41 ++++
 rtl/mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
//   Bundle between the multicycle control unit and the RV32I datapath.
//   master : the controller side (consumes opcode/flags, drives controls).
//   slave  : the datapath side (drives opcode/flags, consumes controls).
//   Datapath -> controller : op, funct3, Zero, mem_ready
//   Controller -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
//                            Illegal, state (debug)
// ---------------------------------------------------------------------------
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       Illegal;
    logic [3:0] state;

    modport master (
        input  op, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, state
    );

    modport slave (
        output op, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Moore control FSM for a multicycle RV32I core with a shared ALU and a
//   unified instruction/data memory.
//   Parameters:
//     WAIT_MEM      : 1 = memory states wait for mem_ready, 0 = never wait
//     SUPPORT_UPPER : 1 = lui/auipc decoded, 0 = they are illegal
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : mc_controller_if.master (opcode/flags in, controls out)
// ---------------------------------------------------------------------------
module mc_controller #(
    parameter bit WAIT_MEM      = 1'b1,
    parameter bit SUPPORT_UPPER = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    mc_controller_if.master bus
);
    // Encodings are exported on bus.state and must stay 0..13 in this order.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JALR     = 4'd10,
        JAL      = 4'd11,
        UPPER    = 4'd12,
        ILLEGAL  = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t     state_q, state_d;
    logic       rdy;
    logic       taken;
    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    assign rdy = WAIT_MEM ? bus.mem_ready : 1'b1;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                // PC+4 computed on the ALU and written straight to PC.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_update  = rdy;
                state_d    = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                // OldPC+imm precomputed into ALUOut for branches and jal.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_IALU:           state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI, OP_AUIPC:  state_d = SUPPORT_UPPER ? UPPER : ILLEGAL;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JALR: begin
                // rs1+imm replaces the DECODE target held in ALUOut.
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = JAL;
            end
            JAL: begin
                // PC <- ALUOut while the ALU forms OldPC+4 for the link write.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            UPPER: begin
                alu_src_a = (bus.op == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            default: begin
                // ILLEGAL and the unreachable encodings 14/15.
                illegal = 1'b1;
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_STORE:         bus.ImmSrc = 3'b001;
            OP_BRANCH:        bus.ImmSrc = 3'b010;
            OP_JAL:           bus.ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
            default:          bus.ImmSrc = 3'b000;
        endcase
    end

    // NOTE: reset forces state to FETCH, whose decode would otherwise raise
    // IRWrite/PCWrite; gating the strobes with reset_n keeps them quiet.
    assign bus.PCWrite   = reset_n & (pc_update | (branch & taken));
    assign bus.IRWrite   = reset_n & ir_write;
    assign bus.RegWrite  = reset_n & reg_write;
    assign bus.MemWrite  = reset_n & mem_write;
    assign bus.Illegal   = reset_n & illegal;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//   Two controllers: dut0 (WAIT_MEM=1, SUPPORT_UPPER=1) and dut1 (WAIT_MEM=0,
//   SUPPORT_UPPER=0) share the stimulus; `sel` picks the one being checked.
//   For each instruction a per-cycle plan is built from the instruction class
//   (cycle list, memory stalls, expected strobes and mux selects), then played
//   against the DUT cycle by cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_controller;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [6:0] op        = 7'd0;
    logic [2:0] funct3    = 3'd0;
    logic       zero      = 1'b0;
    logic       mem_ready = 1'b0;
    logic       sel       = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    always #5 clk = ~clk;

    mc_controller_if bus0();
    mc_controller_if bus1();

    assign bus0.op = op;  assign bus0.funct3 = funct3;
    assign bus0.Zero = zero;  assign bus0.mem_ready = mem_ready;
    assign bus1.op = op;  assign bus1.funct3 = funct3;
    assign bus1.Zero = zero;  assign bus1.mem_ready = mem_ready;

    mc_controller #(.WAIT_MEM(1'b1), .SUPPORT_UPPER(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    mc_controller #(.WAIT_MEM(1'b0), .SUPPORT_UPPER(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // Observed values: strobes {PCWrite,IRWrite,RegWrite,MemWrite,Illegal},
    // selects {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
    logic [3:0] obs_state;
    logic [4:0] obs_we;
    logic [8:0] obs_mux;
    logic [2:0] obs_imm;
    assign obs_state = sel ? bus1.state : bus0.state;
    assign obs_we  = sel ? {bus1.PCWrite, bus1.IRWrite, bus1.RegWrite, bus1.MemWrite, bus1.Illegal}
                         : {bus0.PCWrite, bus0.IRWrite, bus0.RegWrite, bus0.MemWrite, bus0.Illegal};
    assign obs_mux = sel ? {bus1.AdrSrc, bus1.ResultSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp}
                         : {bus0.AdrSrc, bus0.ResultSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp};
    assign obs_imm = sel ? bus1.ImmSrc : bus0.ImmSrc;

    typedef struct packed {
        logic       rdy;
        logic [3:0] st;
        logic [4:0] we;
        logic [8:0] mux;
    } cyc_t;

    cyc_t plan[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] m(input logic adr, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop);
        return {adr, rs, a, b, aop};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == OP_STORE)                 return 3'b001;
        if (o == OP_BRANCH)                return 3'b010;
        if (o == OP_JAL)                   return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC)  return 3'b100;
        return 3'b000;
    endfunction

    task automatic add(input logic rdy, input logic [3:0] st, input logic [4:0] we,
                       input logic [8:0] mux);
        cyc_t c;
        c.rdy = rdy; c.st = st; c.we = we; c.mux = mux;
        plan.push_back(c);
    endtask

    // Memory access cycle: `stalls` cycles with mem_ready low, then the
    // completing one. Without WAIT_MEM mem_ready is held low and ignored.
    task automatic add_mem(input bit wm, input int stalls, input logic [3:0] st,
                           input logic [4:0] we_busy, input logic [4:0] we_done,
                           input logic [8:0] mux);
        if (wm) for (int i = 0; i < stalls; i++) add(1'b0, st, we_busy, mux);
        add(wm, st, we_done, mux);
    endtask

    task automatic build(input bit wm, input bit su, input logic [6:0] o,
                         input logic [2:0] f3, input logic z, input int sf, input int sm);
        logic       tk;
        logic [8:0] wb_mux;
        plan.delete();
        tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
        wb_mux = m(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add_mem(wm, sf, 4'd0, 5'b00000, 5'b11000, m(1'b0, 2'b10, 2'b00, 2'b10, 2'b00));
        add(wm, 4'd1, 5'b00000, m(1'b0, 2'b00, 2'b01, 2'b01, 2'b00));
        if (o == OP_LOAD) begin
            add(wm, 4'd2, 5'b00000, m(1'b0, 2'b00, 2'b10, 2'b01, 2'b00));
            add_mem(wm, sm, 4'd3, 5'b00000, 5'b00000, m(1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
            add(wm, 4'd4, 5'b00100, m(1'b0, 2'b01, 2'b00, 2'b00, 2'b00));
        end else if (o == OP_STORE) begin
            add(wm, 4'd2, 5'b00000, m(1'b0, 2'b00, 2'b10, 2'b01, 2'b00));
            add_mem(wm, sm, 4'd5, 5'b00010, 5'b00010, m(1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
        end else if (o == OP_RTYPE || o == OP_IALU) begin
            add(wm, (o == OP_RTYPE) ? 4'd6 : 4'd7, 5'b00000,
                m(1'b0, 2'b00, 2'b10, (o == OP_RTYPE) ? 2'b00 : 2'b01, 2'b10));
            add(wm, 4'd8, 5'b00100, wb_mux);
        end else if (o == OP_BRANCH) begin
            add(wm, 4'd9, {tk, 4'b0000}, m(1'b0, 2'b00, 2'b10, 2'b00, 2'b01));
        end else if (o == OP_JAL || o == OP_JALR) begin
            if (o == OP_JALR) add(wm, 4'd10, 5'b00000, m(1'b0, 2'b00, 2'b10, 2'b01, 2'b00));
            add(wm, 4'd11, 5'b10000, m(1'b0, 2'b00, 2'b01, 2'b10, 2'b00));
            add(wm, 4'd8, 5'b00100, wb_mux);
        end else if ((o == OP_LUI || o == OP_AUIPC) && su) begin
            add(wm, 4'd12, 5'b00000,
                m(1'b0, 2'b00, (o == OP_LUI) ? 2'b11 : 2'b01, 2'b01, 2'b00));
            add(wm, 4'd8, 5'b00100, wb_mux);
        end else begin
            add(wm, 4'd13, 5'b00001, wb_mux);
        end
    endtask

    // Starts and ends half a cycle before a negedge (#1 after a posedge),
    // with the selected DUT sitting in FETCH.
    task automatic run(input bit wm, input bit su, input logic [6:0] o,
                       input logic [2:0] f3, input logic z, input int sf, input int sm);
        build(wm, su, o, f3, z, sf, sm);
        op = o; funct3 = f3; zero = z;
        foreach (plan[i]) begin
            mem_ready = plan[i].rdy;
            @(negedge clk);
            check($sformatf("state op=%b c%0d", o, i), 32'(obs_state), 32'(plan[i].st));
            check($sformatf("strobes op=%b c%0d", o, i), 32'(obs_we), 32'(plan[i].we));
            check($sformatf("selects op=%b c%0d", o, i), 32'(obs_mux), 32'(plan[i].mux));
            check($sformatf("ImmSrc op=%b c%0d", o, i), 32'(obs_imm), 32'(imm_of(o)));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input bit s);
        sel = s; reset_n = 1'b0; mem_ready = 1'b1; op = OP_LOAD;
        repeat (3) begin
            @(negedge clk);
            check("reset state", 32'(obs_state), 32'd0);
            check("reset strobes", 32'(obs_we), 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic run_random(input bit wm, input bit su, input int n);
        logic [6:0] ops [9];
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH,
                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int k = 0; k < n; k++) begin
            int         idx;
            logic [6:0] o;
            idx = int'($urandom_range(0, 9));
            o = (idx == 9) ? 7'($urandom) : ops[idx];
            run(wm, su, o, 3'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        // WAIT_MEM=1, SUPPORT_UPPER=1
        do_reset(1'b0);
        run(1'b1, 1'b1, OP_LOAD,   3'b000, 1'b0, 2, 1);  // 8 cycles with stalls
        run(1'b1, 1'b1, OP_BRANCH, 3'b001, 1'b0, 0, 0);  // bne taken
        run(1'b1, 1'b1, OP_BRANCH, 3'b001, 1'b1, 0, 0);  // bne not taken
        run(1'b1, 1'b1, OP_BRANCH, 3'b000, 1'b1, 0, 0);  // beq taken
        run(1'b1, 1'b1, OP_BRANCH, 3'b100, 1'b1, 0, 0);  // other funct3 never taken
        run(1'b1, 1'b1, OP_JALR,   3'b000, 1'b0, 0, 0);
        run(1'b1, 1'b1, OP_LUI,    3'b000, 1'b0, 0, 0);
        run(1'b1, 1'b1, OP_AUIPC,  3'b000, 1'b0, 0, 0);
        run(1'b1, 1'b1, OP_STORE,  3'b010, 1'b0, 1, 2);
        run_random(1'b1, 1'b1, 80);

        // Reset asserted mid-instruction: lw reaches MEMADR, then reset
        // must drop state to FETCH before any clock edge.
        op = OP_LOAD; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset state", 32'(obs_state), 32'd2);
        reset_n = 1'b0;
        #1;
        check("async reset state", 32'(obs_state), 32'd0);
        check("async reset strobes", 32'(obs_we), 32'd0);

        // WAIT_MEM=0, SUPPORT_UPPER=0
        do_reset(1'b1);
        run(1'b0, 1'b0, OP_LUI,   3'b000, 1'b0, 0, 0);   // illegal without upper
        run(1'b0, 1'b0, OP_STORE, 3'b010, 1'b0, 0, 0);   // mem_ready held low
        run(1'b0, 1'b0, OP_LOAD,  3'b010, 1'b0, 0, 0);
        run(1'b0, 1'b0, 7'b1110011, 3'b000, 1'b0, 0, 0); // unsupported opcode
        run_random(1'b0, 1'b0, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
